pulse_sweep_sched: RTL and testbench
====================================

Name: pulse_sweep_sched

Overview:
- Sequences the pulse generator through a delay sweep.
- Steps the pi-pulse delay over n_steps values and holds each value for a programmed number of shots (generator periods).
- Drives a one-cycle parameter-load strobe only at period boundaries, so no shot ever sees a mid-period parameter change.
- Sits between the host/UART register block and the pulse generator, on the same clock as the generator's parameter-capture logic.

Parameters:
- DEL_W, 16, width of delay values and step.
- SHOT_W, 16, width of shots-per-step counter.
- STEP_W, 8, width of step index / step count.
- DISCARD, 2, shots after each load flagged invalid (settling); 0 disables.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle sweep start request.
- abort  in  1  one-cycle abort request.
- del_start  in  DEL_W  first delay value, cycles.
- del_step  in  DEL_W  delay increment per step, unsigned.
- n_steps  in  STEP_W  number of delay values in the sweep.
- shots  in  SHOT_W  shots per step.
- period_end  in  1  one-cycle strobe from the generator at counter wrap.
- del  out  DEL_W  delay value presented to the generator.
- load  out  1  one-cycle parameter-update strobe to the generator.
- acq_valid  out  1  high during shots that count toward acquisition.
- step_idx  out  STEP_W  current step, 0-based.
- shot_cnt  out  SHOT_W  shots completed in the current step.
- busy  out  1  high in ARM or RUN.
- done  out  1  one-cycle pulse on sweep completion or error stop.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset values (asynchronous): state=IDLE. del=0, load=0, acq_valid=0, step_idx=0, shot_cnt=0, busy=0, done=0, err=0.
- States:
  - IDLE: waiting for start.
  - ARM: waiting for the first boundary.
  - RUN: counting shots.
  - DONE: single cycle, then IDLE.
- IDLE with start=1:
  - If n_steps==0 or shots==0: err<=1, done pulses next cycle, stay IDLE.
  - Otherwise: latch del_step, n_steps, shots. del<=del_start, err<=0, step_idx<=0, shot_cnt<=0, go ARM.
  - start outside IDLE is ignored.
- ARM, on period_end:
  - load=1 in the following cycle (del already stable, at least 1 cycle before load).
  - Go RUN; discard counter loaded with DISCARD.
- RUN, each period_end:
  - If the discard counter is nonzero: decrement it; shot_cnt is unchanged.
  - Else: shot_cnt+1.
  - acq_valid = (state==RUN && discard counter==0). It changes only in the cycle after period_end.
- Step end: on the period_end that makes shot_cnt reach shots.
  - If step_idx==n_steps-1: go DONE, done=1 for one cycle, acq_valid<=0, no load. del and step_idx hold their final values.
  - Else: step_idx+1, del<=del+del_step, shot_cnt<=0, discard counter<=DISCARD, load=1 the next cycle.
- Arithmetic: the del+del_step sum is computed DEL_W+1 wide. On carry: err<=1, go DONE, del unchanged, no load.
- load latency: exactly 1 cycle after the qualifying period_end. Never asserted in consecutive cycles.
- abort in ARM or RUN: IDLE next cycle; busy, acq_valid and load go low; done not pulsed; err unchanged; del holds.
- abort and period_end in the same cycle: abort wins; no load, no count.
- start and abort in the same cycle in IDLE: abort wins; start is ignored.
- period_end in IDLE or DONE: ignored.
- busy = state is ARM or RUN.
- reset asserted mid-sweep: immediate return to reset values. No load or done is emitted on reset release.

Test Plan:
- Basic sweep: DISCARD=0, del_start=200, del_step=10, n_steps=3, shots=2, period_end every 50 cycles. Expect:
  - load pulses at boundaries 1, 3, 5, with del=200, 210, 220.
  - done one cycle after the 7th boundary; err=0.
- Settling: DISCARD=2, shots=1, n_steps=2. Expect acq_valid low for 2 periods after each load and high for 1; done after the 7th boundary.
- Overflow: del_start=0xFFF0, del_step=0x20, n_steps=4, shots=1. Expect:
  - err=1 and done at the 2nd boundary.
  - del stays 0xFFF0; only one load.
- Abort: abort during step_idx=1 of a 3-step sweep, coincident with period_end. Expect:
  - IDLE next cycle, busy=0, no load, no done.
  - A subsequent start runs a full sweep cleanly.
- Illegal config: start with shots=0. Expect err=1, done one-cycle pulse, busy never high.
- Async reset: assert reset between clock edges during RUN. Expect all outputs at reset values before the next clk edge; no spurious load after release.

Source files
------------

// File: rtl/pulse_sweep_sched.sv
// rtl/pulse_sweep_sched.sv - delay-sweep sequencer for the pulse generator
//
// Steps the pi-pulse delay through n_steps values, holding each value for a
// programmed number of generator periods (shots). New parameters are only
// handed to the generator via a one-cycle load strobe that follows a period
// boundary, so no shot ever straddles a parameter change. The first DISCARD
// shots after every load are flagged invalid while the hardware settles.
//
// Ports:
//   clk        system clock (shared with the generator's capture logic)
//   reset      asynchronous, active-high reset
//   start      one-cycle sweep start request (honoured only in IDLE)
//   abort      one-cycle abort request (ARM/RUN), wins over everything else
//   del_start  first delay value, cycles
//   del_step   delay increment per step, unsigned
//   n_steps    number of delay values in the sweep
//   shots      shots per step
//   period_end one-cycle strobe from the generator at counter wrap
//   del        delay value presented to the generator
//   load       one-cycle parameter-update strobe to the generator
//   acq_valid  high during shots that count toward acquisition
//   step_idx   current step, 0-based
//   shot_cnt   shots completed in the current step
//   busy       high while arming or running
//   done       one-cycle pulse on completion or error stop
//   err        sticky error flag, cleared by the next accepted start

module pulse_sweep_sched #(
    parameter int DEL_W   = 16,
    parameter int SHOT_W  = 16,
    parameter int STEP_W  = 8,
    parameter int DISCARD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DEL_W-1:0]  del_start,
    input  logic [DEL_W-1:0]  del_step,
    input  logic [STEP_W-1:0] n_steps,
    input  logic [SHOT_W-1:0] shots,
    input  logic              period_end,
    output logic [DEL_W-1:0]  del,
    output logic              load,
    output logic              acq_valid,
    output logic [STEP_W-1:0] step_idx,
    output logic [SHOT_W-1:0] shot_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // A discard counter of at least one bit keeps the DISCARD=0 build legal;
    // it simply never leaves zero in that case.
    localparam int DISC_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
    localparam logic [DISC_W-1:0] DISC_INIT = DISC_W'(DISCARD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Sweep configuration captured at start so the host may rewrite its
    // registers while a sweep is in flight.
    logic [DEL_W-1:0]  del_step_r, del_step_nxt;
    logic [STEP_W-1:0] n_steps_r,  n_steps_nxt;
    logic [SHOT_W-1:0] shots_r,    shots_nxt;

    logic [DISC_W-1:0] disc_cnt, disc_nxt;
    logic [DEL_W-1:0]  del_nxt;
    logic [STEP_W-1:0] step_idx_nxt;
    logic [SHOT_W-1:0] shot_cnt_nxt;
    logic              load_nxt;
    logic              done_nxt;
    logic              err_nxt;

    // One extra bit catches delay wrap-around before it reaches the generator.
    logic [DEL_W:0]    del_sum;
    logic [SHOT_W-1:0] shot_inc;
    logic              last_step;
    logic              cfg_bad;

    assign del_sum   = {1'b0, del} + {1'b0, del_step_r};
    assign shot_inc  = shot_cnt + SHOT_W'(1);
    assign last_step = (step_idx == (n_steps_r - STEP_W'(1)));
    assign cfg_bad   = (n_steps == '0) || (shots == '0);

    assign busy      = (state == S_ARM) || (state == S_RUN);
    // Discard counter only moves on period_end, so acq_valid only ever
    // changes in the cycle after a boundary.
    assign acq_valid = (state == S_RUN) && (disc_cnt == '0);

    always_comb begin
        state_nxt    = state;
        del_nxt      = del;
        step_idx_nxt = step_idx;
        shot_cnt_nxt = shot_cnt;
        disc_nxt     = disc_cnt;
        del_step_nxt = del_step_r;
        n_steps_nxt  = n_steps_r;
        shots_nxt    = shots_r;
        err_nxt      = err;
        load_nxt     = 1'b0;
        done_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_bad) begin
                        err_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end else begin
                        del_step_nxt = del_step;
                        n_steps_nxt  = n_steps;
                        shots_nxt    = shots;
                        del_nxt      = del_start;
                        err_nxt      = 1'b0;
                        step_idx_nxt = '0;
                        shot_cnt_nxt = '0;
                        state_nxt    = S_ARM;
                    end
                end
            end

            S_ARM: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (period_end) begin
                    // del has been stable since start, well ahead of load.
                    load_nxt  = 1'b1;
                    disc_nxt  = DISC_INIT;
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (period_end) begin
                    if (disc_cnt != '0) begin
                        disc_nxt = disc_cnt - DISC_W'(1);
                    end else if (shot_inc != shots_r) begin
                        shot_cnt_nxt = shot_inc;
                    end else if (last_step) begin
                        shot_cnt_nxt = shot_inc;
                        done_nxt     = 1'b1;
                        state_nxt    = S_DONE;
                    end else if (del_sum[DEL_W]) begin
                        // Next delay would wrap: stop rather than emit it.
                        shot_cnt_nxt = shot_inc;
                        err_nxt      = 1'b1;
                        done_nxt     = 1'b1;
                        state_nxt    = S_DONE;
                    end else begin
                        del_nxt      = del_sum[DEL_W-1:0];
                        step_idx_nxt = step_idx + STEP_W'(1);
                        shot_cnt_nxt = '0;
                        disc_nxt     = DISC_INIT;
                        load_nxt     = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            del        <= '0;
            step_idx   <= '0;
            shot_cnt   <= '0;
            disc_cnt   <= '0;
            del_step_r <= '0;
            n_steps_r  <= '0;
            shots_r    <= '0;
            load       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            del        <= del_nxt;
            step_idx   <= step_idx_nxt;
            shot_cnt   <= shot_cnt_nxt;
            disc_cnt   <= disc_nxt;
            del_step_r <= del_step_nxt;
            n_steps_r  <= n_steps_nxt;
            shots_r    <= shots_nxt;
            load       <= load_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_sweep_sched.sv
// tb/tb_pulse_sweep_sched.sv - self-checking bench for pulse_sweep_sched
module tb_pulse_sweep_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        period_end = 1'b0;
    logic [15:0] del_start = '0;
    logic [15:0] del_step = '0;
    logic [7:0]  n_steps = '0;
    logic [15:0] shots = '0;

    logic [15:0] del_o [2];
    logic        load_o [2];
    logic        acq_o [2];
    logic [7:0]  step_o [2];
    logic [15:0] shot_o [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic        err_o [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pulse_sweep_sched #(.DEL_W(16), .SHOT_W(16), .STEP_W(8), .DISCARD(0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .del_start(del_start), .del_step(del_step), .n_steps(n_steps), .shots(shots),
        .period_end(period_end), .del(del_o[0]), .load(load_o[0]), .acq_valid(acq_o[0]),
        .step_idx(step_o[0]), .shot_cnt(shot_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .err(err_o[0])
    );

    pulse_sweep_sched #(.DEL_W(16), .SHOT_W(16), .STEP_W(8), .DISCARD(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .del_start(del_start), .del_step(del_step), .n_steps(n_steps), .shots(shots),
        .period_end(period_end), .del(del_o[1]), .load(load_o[1]), .acq_valid(acq_o[1]),
        .step_idx(step_o[1]), .shot_cnt(shot_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .err(err_o[1])
    );

    // Reference model: tracks the sweep by counting boundaries since arming and
    // derives step/shot/delay from that count with plain arithmetic.
    // phase: 0 idle, 1 armed, 2 running, 3 done-cycle
    typedef struct {
        int phase; int b; int err; int load; int done; int acq;
        int n; int s; int ds; int dstep; int del; int step; int shot;
    } model_t;
    model_t md [2];

    function automatic int dsc(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            model_t m;
            int d, per, mm, k, r;
            m = md[i];
            d = dsc(i);
            if (reset) begin
                m = '{default: 0};
            end else begin
                m.load = 0;
                m.done = 0;
                if (m.phase == 3) begin
                    m.phase = 0;
                end else if (m.phase == 0) begin
                    if (start && !abort) begin
                        if (n_steps == 0 || shots == 0) begin
                            m.err = 1;
                            m.done = 1;
                        end else begin
                            m.n = int'(n_steps); m.s = int'(shots);
                            m.ds = int'(del_start); m.dstep = int'(del_step);
                            m.del = m.ds; m.step = 0; m.shot = 0; m.err = 0;
                            m.acq = 0; m.b = 0; m.phase = 1;
                        end
                    end
                end else if (abort) begin
                    m.phase = 0;
                    m.acq = 0;
                end else if (period_end) begin
                    m.b++;
                    if (m.phase == 1) begin
                        m.phase = 2;
                        m.load = 1;
                        m.acq = (d == 0);
                    end else begin
                        per = d + m.s;
                        mm = m.b - 1;
                        k = mm / per;
                        r = mm % per;
                        if (r == 0) begin
                            if (k == m.n || m.ds + k * m.dstep > 65535) begin
                                if (k != m.n) m.err = 1;
                                m.phase = 3; m.done = 1; m.acq = 0; m.shot = m.s;
                            end else begin
                                m.step = k; m.del = m.ds + k * m.dstep;
                                m.shot = 0; m.load = 1; m.acq = (d == 0);
                            end
                        end else begin
                            m.shot = (r > d) ? r - d : 0;
                            m.acq = (r >= d);
                        end
                    end
                end
            end
            md[i] = m;
        end
    endtask

    function automatic logic [44:0] exp_vec(input int i);
        logic [15:0] dl, sh;
        logic [7:0] st;
        logic bz;
        dl = md[i].del[15:0];
        sh = md[i].shot[15:0];
        st = md[i].step[7:0];
        bz = (md[i].phase == 1 || md[i].phase == 2);
        return {dl, md[i].load[0], md[i].acq[0], st, sh, bz, md[i].done[0], md[i].err[0]};
    endfunction

    function automatic logic [44:0] act_vec(input int i);
        return {del_o[i], load_o[i], acq_o[i], step_o[i], shot_o[i], busy_o[i], done_o[i], err_o[i]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("cycle_dut%0d", i), 64'(act_vec(i)), 64'(exp_vec(i)));
    endtask

    task automatic rand_cfg();
        del_start = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFF00, 16'hFFFF)) : 16'($urandom);
        del_step  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40)) : 16'($urandom);
        n_steps   = 8'($urandom_range(0, 4));
        shots     = 16'($urandom_range(0, 3));
    endtask

    typedef struct {
        logic [15:0] ds; logic [15:0] dstep; logic [7:0] n; logic [15:0] s; int per;
        int loads0; int loads1; int done0; int done1; logic err; logic [15:0] fdel;
    } vec_t;

    int obs_loads [2];
    int obs_done_at [2];
    bit obs_seen [2];
    int obs_pe;

    task automatic observe();
        for (int i = 0; i < 2; i++) begin
            if (load_o[i]) obs_loads[i]++;
            if (done_o[i] && !obs_seen[i]) begin
                obs_seen[i] = 1'b1;
                obs_done_at[i] = obs_pe;
            end
        end
    endtask

    task automatic run_sweep(input vec_t v, input int t);
        int cyc;
        for (int i = 0; i < 2; i++) begin
            obs_loads[i] = 0; obs_done_at[i] = -1; obs_seen[i] = 1'b0;
        end
        obs_pe = 0;
        del_start = v.ds; del_step = v.dstep; n_steps = v.n; shots = v.s;
        period_end = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        observe();
        cyc = 0;
        while (!(obs_seen[0] && obs_seen[1]) && cyc < 3000) begin
            cyc++;
            period_end = (cyc % v.per == 0);
            if (period_end) obs_pe++;
            tick();
            observe();
        end
        period_end = 1'b0;
        if (!(obs_seen[0] && obs_seen[1])) begin
            total++; bad++;
            $display("FAIL vec%0d_timeout actual=no_done required=done", t);
        end
        repeat (3) tick();
        chk($sformatf("vec%0d_loads_d0", t), 64'(obs_loads[0]), 64'(v.loads0));
        chk($sformatf("vec%0d_loads_d2", t), 64'(obs_loads[1]), 64'(v.loads1));
        chk($sformatf("vec%0d_done_at_d0", t), 64'(obs_done_at[0]), 64'(v.done0));
        chk($sformatf("vec%0d_done_at_d2", t), 64'(obs_done_at[1]), 64'(v.done1));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("vec%0d_err_dut%0d", t, i), 64'(err_o[i]), 64'(v.err));
            chk($sformatf("vec%0d_del_dut%0d", t, i), 64'(del_o[i]), 64'(v.fdel));
            chk($sformatf("vec%0d_idle_dut%0d", t, i), 64'(busy_o[i]), 64'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int cyc;
        bit aborted;
        int p;

        tbl[0] = '{16'd200,   16'd10,   8'd3, 16'd2, 50, 3, 3, 7, 13, 1'b0, 16'd220};
        tbl[1] = '{16'd300,   16'd5,    8'd2, 16'd1,  9, 2, 2, 3,  7, 1'b0, 16'd305};
        tbl[2] = '{16'hFFF0,  16'h20,   8'd4, 16'd1,  5, 1, 1, 2,  4, 1'b1, 16'hFFF0};
        tbl[3] = '{16'd100,   16'd1,    8'd3, 16'd0,  4, 0, 0, 0,  0, 1'b1, 16'hFFF0};
        tbl[4] = '{16'd7,     16'd1,    8'd0, 16'd5,  4, 0, 0, 0,  0, 1'b1, 16'hFFF0};
        tbl[5] = '{16'd40,    16'd9,    8'd1, 16'd3,  2, 1, 1, 4,  6, 1'b0, 16'd40};
        tbl[6] = '{16'hFFE0,  16'h10,   8'd3, 16'd1,  3, 2, 2, 3,  7, 1'b1, 16'hFFF0};
        tbl[7] = '{16'hFFEF,  16'h8,    8'd3, 16'd1,  4, 3, 3, 4, 10, 1'b0, 16'hFFFF};

        for (int i = 0; i < 2; i++) md[i] = '{default: 0};
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("reset_state_dut%0d", i), 64'(act_vec(i)), 64'(0));
        repeat (2) tick();
        reset = 1'b0;
        tick();

        for (int t = 0; t < 8; t++) run_sweep(tbl[t], t);

        // Abort coincident with a boundary while step 1 is running.
        del_start = 16'd100; del_step = 16'd5; n_steps = 8'd3; shots = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        aborted = 1'b0;
        while (!aborted && cyc < 400) begin
            cyc++;
            period_end = (cyc % 4 == 0);
            abort = period_end && busy_o[0] && (step_o[0] == 8'd1);
            aborted = abort;
            tick();
        end
        abort = 1'b0;
        period_end = 1'b0;
        chk("abort_reached", 64'(aborted), 64'(1));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("abort_busy_dut%0d", i), 64'(busy_o[i]), 64'(0));
            chk($sformatf("abort_load_dut%0d", i), 64'(load_o[i]), 64'(0));
            chk($sformatf("abort_done_dut%0d", i), 64'(done_o[i]), 64'(0));
        end
        chk("abort_step_hold", 64'(step_o[0]), 64'(1));
        repeat (3) begin
            tick();
            for (int i = 0; i < 2; i++) chk($sformatf("post_abort_done_dut%0d", i), 64'(done_o[i]), 64'(0));
        end
        run_sweep(tbl[0], 8);

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 2; i++) chk($sformatf("start_abort_busy_dut%0d", i), 64'(busy_o[i]), 64'(0));
        tick();
        for (int i = 0; i < 2; i++) chk($sformatf("start_abort_done_dut%0d", i), 64'(done_o[i]), 64'(0));

        // Asynchronous reset between clock edges during RUN.
        del_start = 16'd500; del_step = 16'd3; n_steps = 8'd4; shots = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            period_end = (c % 3 == 0);
            tick();
        end
        period_end = 1'b0;
        chk("areset_pre_busy", 64'(busy_o[0]), 64'(1));
        #3;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) chk($sformatf("areset_outs_dut%0d", i), 64'(act_vec(i)), 64'(0));
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            period_end = (c % 2 == 0);
            tick();
            for (int i = 0; i < 2; i++) chk($sformatf("areset_noload_dut%0d", i), 64'(load_o[i]), 64'(0));
        end
        period_end = 1'b0;

        // Randomized sweeps with stray starts, aborts and register rewrites.
        for (int it = 0; it < 30; it++) begin
            rand_cfg();
            start = 1'b1;
            tick();
            start = 1'b0;
            p = $urandom_range(2, 6);
            for (int c = 1; c <= 160; c++) begin
                period_end = (c % p == 0);
                abort = ($urandom_range(0, 149) == 0);
                start = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 9) == 0) rand_cfg();
                tick();
            end
            start = 1'b0;
            abort = 1'b0;
            period_end = 1'b0;
            repeat (2) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
